jk_reg_bank: RTL

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_bank_pkg.sv | 11 +
 rtl/jk_cell.sv | 38 +++
 rtl/jk_reg_bank.sv | 102 ++++++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
// Shared mode encoding for the JK register bank.
package jk_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK  = 2'b00;
    localparam mode_t MODE_UP  = 2'b01;
    localparam mode_t MODE_DN  = 2'b10;
    localparam mode_t MODE_SHL = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable and synchronous active-low reset to a
// per-cell value.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            case ({j, k})
                2'b00:   state_d = state_q;
                2'b01:   state_d = 1'b0;
                2'b10:   state_d = 1'b1;
                default: state_d = ~state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= rst_val;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells steered into JK, up/down counter or shift-left modes.
// Optional macro JK_BANK_SAT_EN makes the counter modes saturate instead of wrap.
module jk_reg_bank
    import jk_bank_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             tc
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             cell_en;
    logic             tc_w;
    logic             sat_hold;

    // Toggle conditions: bit i flips when every lower bit is 1 (up) or 0 (down).
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign up_t[gi] = up_t[gi-1] & q_w[gi-1];
            assign dn_t[gi] = dn_t[gi-1] & ~q_w[gi-1];
        end
    endgenerate

    assign shl_v = {q_w[WIDTH-2:0], sin};

    assign tc_w = ((mode == MODE_UP) && (&q_w)) ||
                  ((mode == MODE_DN) && (~|q_w));

`ifdef JK_BANK_SAT_EN
    assign sat_hold = tc_w;
`else
    assign sat_hold = 1'b0;
`endif

    always_comb begin
        cell_j  = j;
        cell_k  = k;
        cell_en = en & ~sat_hold;
        if (load) begin
            cell_j  = d;
            cell_k  = ~d;
            cell_en = 1'b1;
        end else begin
            case (mode)
                MODE_UP: begin
                    cell_j = up_t;
                    cell_k = up_t;
                end
                MODE_DN: begin
                    cell_j = dn_t;
                    cell_k = dn_t;
                end
                MODE_SHL: begin
                    cell_j = shl_v;
                    cell_k = ~shl_v;
                end
                default: begin
                    cell_j = j;
                    cell_k = k;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .rst_val (RST_VAL[gi]),
                .en      (cell_en),
                .j       (cell_j[gi]),
                .k       (cell_k[gi]),
                .q       (q_w[gi])
            );
        end
    endgenerate

    assign q   = q_w;
    assign q_b = ~q_w;
    assign tc  = tc_w;

endmodule
